// File: rtl/mem_share_arbiter_pkg.sv
// Shared definitions for the main-memory sharing arbiter: FSM state
// encoding, default memory geometry and the fixed requester slot numbers.
package mem_share_arbiter_pkg;

  // Default main-memory geometry (single-port RAM).
  localparam int MEM_AW = 11;
  localparam int MEM_DW = 32;

  // Requester slot assignment on the req/ack/enable vectors.
  localparam int REQ_CPU  = 0;  // CPU controller
  localparam int REQ_DRAW = 1;  // draw-to-VGA engine
  localparam int REQ_WTR  = 2;  // write-to-RAM engine
  localparam int REQ_STR  = 3;  // save-to-low-RAM engine

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_share_arbiter_rr_pick.sv
// Rotating-priority pick: returns the first set request bit found when
// scanning last+1, last+2, ... modulo N_REQ. Purely combinational so it can
// be reused by other arbiters.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Scan the requesters starting just after the last grantee, wrapping at N_REQ.
  always_comb begin
    int cand;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    valid = 1'b0;
    index = last;
    cand  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(last) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_share_arbiter.sv
// Round-robin arbiter sharing the single-port main memory between the
// requester engines. One engine at a time is enabled; its address, data and
// write enable are steered onto the RAM port until it acknowledges or
// withdraws, then a one-cycle TURN gap parks the RAM port before the next
// owner is picked.
// Optional build macro MEM_ARB_TIMEOUT_EN: adds a grant-length counter that
// aborts a grant after TIMEOUT_CYCLES cycles and pulses timeout.
module mem_share_arbiter
  import mem_share_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int AW             = MEM_AW,
  parameter int DW             = MEM_DW,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       CLOCK_50,
  input  logic                       resetIn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           ack,
  input  logic [N_REQ*AW-1:0]        addr_in,
  input  logic [N_REQ*DW-1:0]        wdata_in,
  input  logic [N_REQ-1:0]           we_in,
  output logic [N_REQ-1:0]           enable,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  output logic                       mem_we,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic                       timeout
);

  localparam int OW = $clog2(N_REQ);

  arb_state_t    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          pick_valid;
  logic [OW-1:0] pick_idx;
  logic          owner_done;
  logic          abort;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (OW)
  ) u_pick (
    .req   (req),
    .last  (owner_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // The grant ends on the owner's ack or when the owner drops its request;
  // both lead to the same TURN, so a simultaneous ack and withdraw is a normal completion.
  assign owner_done = ack[owner_q] || !req[owner_q];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] grant_cnt_q;
  logic          timeout_q;

  // An abort only fires when the owner has not completed in the same cycle.
  assign abort = (state_q == ST_GRANT) && !owner_done &&
                 (grant_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Grant-length counter: zero outside GRANT, counts each GRANT cycle; timeout pulse register.
  always_ff @(posedge CLOCK_50) begin
    if (resetIn) begin
      grant_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      grant_cnt_q <= (state_q == ST_GRANT) ? grant_cnt_q + 1'b1 : '0;
      timeout_q   <= abort;
    end
  end

  assign timeout = timeout_q;
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign abort              = 1'b0;
  assign timeout            = 1'b0;
`endif

  // State and owner registers; owner resets to the last slot so slot 0 wins first.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (resetIn) begin
      state_q <= ST_IDLE;
      owner_q <= OW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic: pick in IDLE, hold through GRANT, one-cycle TURN gap.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
        end
      end
      ST_GRANT: begin
        if (owner_done || abort) state_d = ST_TURN;
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port steering: the owner's slices in GRANT, parked at zero otherwise.
  always_comb begin
    enable    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (state_q == ST_GRANT) begin
      enable[owner_q] = 1'b1;
      mem_addr        = addr_in[int'(owner_q)*AW +: AW];
      mem_wdata       = wdata_in[int'(owner_q)*DW +: DW];
      mem_we          = we_in[owner_q];
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Self-checking bench for mem_share_arbiter: reset values, a table of
// single-cycle vectors, a reset-mid-grant sequence, a scoreboarded fairness
// run and a withdraw sequence (plus the timeout sequence in feature builds).
module tb_mem_share_arbiter;

  localparam int N_REQ = 4;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int OW    = 2;

  logic                CLOCK_50 = 1'b0;
  logic                resetIn;
  logic [N_REQ-1:0]    req, ack, we_in;
  logic [N_REQ*AW-1:0] addr_in;
  logic [N_REQ*DW-1:0] wdata_in;
  logic [N_REQ-1:0]    enable;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_we;
  logic [OW-1:0]       owner;
  logic                busy, timeout;

  int checks = 0;
  int errors = 0;

  localparam logic [N_REQ-1:0] WE_PAT = 4'b1110;

  typedef struct {
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] en;
    int               owner;
    logic             busy;
  } vec_t;

  vec_t vecs[19];

  // Scoreboard of expected grant order, consumed by the grant monitor.
  int         exp_q[$];
  logic       sb_on = 1'b0;
  logic [3:0] prev_en;
  int         low_cnt;
  bit         have_prev;

  always #10 CLOCK_50 = ~CLOCK_50;

  mem_share_arbiter #(
    .N_REQ          (N_REQ),
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .resetIn   (resetIn),
    .req       (req),
    .ack       (ack),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .we_in     (we_in),
    .enable    (enable),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .owner     (owner),
    .busy      (busy),
    .timeout   (timeout)
  );

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(11'h7FC + i);
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  task automatic load_slices();
    for (int i = 0; i < N_REQ; i++) begin
      addr_in[i*AW +: AW]  = addr_of(i);
      wdata_in[i*DW +: DW] = wdata_of(i);
    end
    we_in = WE_PAT;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (enable != '0) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) check("wait_grant_timeout", {63'd0, enable != '0}, 64'd1);
  endtask

  // Grant monitor: one-hot enable every cycle, grant order from the
  // scoreboard, and exactly two enable-low cycles between consecutive grants.
  always @(posedge CLOCK_50) begin
    #2;
    if (sb_on) begin
      check("sb_onehot", {63'd0, $onehot0(enable)}, 64'd1);
      check("sb_en_outside_busy", {63'd0, (enable != '0) && !busy}, 64'd0);
      if (enable == '0) begin
        low_cnt++;
      end else begin
        if (prev_en == '0) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_grant", 64'(enable), 64'd0);
          end else begin
            int e;
            e = exp_q.pop_front();
            check("sb_owner", 64'(owner), 64'(e));
            check("sb_enable", 64'(enable), 64'(4'b0001 << e));
          end
          if (have_prev) check("sb_gap", 64'(low_cnt), 64'd2);
          have_prev = 1'b1;
        end
        low_cnt = 0;
      end
      prev_en = enable;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
`ifdef MEM_ARB_TIMEOUT_EN
    int hi, pulses;
`endif

    vecs[0]  = '{4'b0100, 4'b0000, 4'b0100, 2, 1'b1};
    vecs[1]  = '{4'b0100, 4'b0000, 4'b0100, 2, 1'b1};
    vecs[2]  = '{4'b0100, 4'b1000, 4'b0100, 2, 1'b1};
    vecs[3]  = '{4'b0100, 4'b0100, 4'b0000, 2, 1'b1};
    vecs[4]  = '{4'b0000, 4'b0000, 4'b0000, 2, 1'b0};
    vecs[5]  = '{4'b0010, 4'b0000, 4'b0010, 1, 1'b1};
    vecs[6]  = '{4'b0010, 4'b0100, 4'b0010, 1, 1'b1};
    vecs[7]  = '{4'b0010, 4'b0010, 4'b0000, 1, 1'b1};
    vecs[8]  = '{4'b0010, 4'b0000, 4'b0000, 1, 1'b0};
    vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 1, 1'b0};
    vecs[10] = '{4'b1001, 4'b0000, 4'b1000, 3, 1'b1};
    vecs[11] = '{4'b1001, 4'b1000, 4'b0000, 3, 1'b1};
    vecs[12] = '{4'b0001, 4'b0000, 4'b0000, 3, 1'b0};
    vecs[13] = '{4'b0001, 4'b0000, 4'b0001, 0, 1'b1};
    vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 0, 1'b1};
    vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 0, 1'b0};
    vecs[16] = '{4'b0100, 4'b0000, 4'b0100, 2, 1'b1};
    vecs[17] = '{4'b0000, 4'b0100, 4'b0000, 2, 1'b1};
    vecs[18] = '{4'b0000, 4'b0000, 4'b0000, 2, 1'b0};

    resetIn = 1'b1;
    req     = '0;
    ack     = '0;
    load_slices();
    tick();
    tick();
    check("rst_enable", 64'(enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd3);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    resetIn = 1'b0;

    // Table-driven vectors: inputs held across one edge, outputs checked after it.
    for (int i = 0; i < 19; i++) begin
      req = vecs[i].req;
      ack = vecs[i].ack;
      tick();
      ea = (vecs[i].en != '0) ? addr_of(vecs[i].owner)   : '0;
      ed = (vecs[i].en != '0) ? wdata_of(vecs[i].owner)  : '0;
      ew = (vecs[i].en != '0) ? WE_PAT[vecs[i].owner]    : 1'b0;
      check($sformatf("v%0d_enable", i), 64'(enable), 64'(vecs[i].en));
      check($sformatf("v%0d_owner", i), 64'(owner), 64'(vecs[i].owner));
      check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
      check($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(ea));
      check($sformatf("v%0d_mem_wdata", i), 64'(mem_wdata), 64'(ed));
      check($sformatf("v%0d_mem_we", i), 64'(mem_we), 64'(ew));
      check($sformatf("v%0d_timeout", i), 64'(timeout), 64'd0);
    end
    req = '0;
    ack = '0;

    // Reset in the middle of a write grant by requester 3.
    addr_in[3*AW +: AW]  = 11'h005;
    wdata_in[3*DW +: DW] = 32'hDEADBEEF;
    req = 4'b1000;
    tick();
    check("rs_enable", 64'(enable), 64'h8);
    check("rs_mem_addr", 64'(mem_addr), 64'h005);
    check("rs_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    check("rs_mem_we", 64'(mem_we), 64'd1);
    resetIn = 1'b1;
    tick();
    check("rs_after_enable", 64'(enable), 64'd0);
    check("rs_after_mem_we", 64'(mem_we), 64'd0);
    check("rs_after_owner", 64'(owner), 64'd3);
    check("rs_after_busy", 64'(busy), 64'd0);
    resetIn = 1'b0;
    req     = '0;
    load_slices();
    tick();

    // Fairness: all requesters held, each owner acks on its third grant cycle.
    prev_en   = '0;
    low_cnt   = 0;
    have_prev = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    sb_on = 1'b1;
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(got);
      if (!got) break;
      tick();
      tick();
      ack = enable;
      if (k == 4) req = '0;
      tick();
      ack = '0;
    end
    repeat (4) tick();
    sb_on = 1'b0;
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    req = '0;

    // Requester 2 withdraws mid-grant without acking.
    req = 4'b0100;
    tick();
    check("wd_grant", 64'(enable), 64'h4);
    tick();
    check("wd_hold", 64'(enable), 64'h4);
    req = '0;
    tick();
    check("wd_turn_enable", 64'(enable), 64'd0);
    check("wd_turn_busy", 64'(busy), 64'd1);
    check("wd_turn_mem_we", 64'(mem_we), 64'd0);
    check("wd_turn_mem_addr", 64'(mem_addr), 64'd0);
    check("wd_turn_timeout", 64'(timeout), 64'd0);
    tick();
    check("wd_idle_busy", 64'(busy), 64'd0);
    check("wd_idle_timeout", 64'(timeout), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Requester 0 never acks; the grant is aborted and requester 1 follows.
    hi     = 0;
    pulses = 0;
    req    = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (enable == 4'b0001) hi++;
      if (timeout) pulses++;
      if (enable == 4'b0010) break;
    end
    check("to_grant_len", 64'(hi), 64'd8);
    check("to_pulses", 64'(pulses), 64'd1);
    check("to_next_owner", 64'(enable), 64'h2);
    req = '0;
    ack = 4'b0010;
    tick();
    ack = '0;
    tick();
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
